// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: register map, op codes and FSM states shared by the SPI-lite sequencer
package spi_seq_pkg;
  localparam logic [6:0] ADDR_SRR   = 7'h40;
  localparam logic [6:0] ADDR_SPICR = 7'h60;
  localparam logic [6:0] ADDR_SPISR = 7'h64;
  localparam logic [6:0] ADDR_DTR   = 7'h68;
  localparam logic [6:0] ADDR_DRR   = 7'h6C;
  localparam logic [6:0] ADDR_SSR   = 7'h70;
  localparam logic [31:0] SRR_KEY   = 32'h0000_000A;
  localparam logic [31:0] SSR_DESEL = 32'hFFFF_FFFF;
  localparam logic [31:0] SSR_SEL   = 32'hFFFF_FFFE;
  typedef enum logic [1:0] {
    OP_XFER        = 2'd0,
    OP_CS_ASSERT   = 2'd1,
    OP_CS_DEASSERT = 2'd2,
    OP_RSVD        = 2'd3
  } op_e;
  typedef enum logic [3:0] {
    S_INIT_SRR,
    S_INIT_CR,
    S_INIT_SS,
    S_IDLE,
    S_CS_ASSERT,
    S_CS_DEASSERT,
    S_WR_DTR,
    S_POLL,
    S_RD_DRR,
    S_RESP
  } state_e;
endpackage

// File: rtl/axi_lite_master_port.sv
// axi_lite_master_port: single-outstanding AXI-lite write/read engine
module axi_lite_master_port
  import spi_seq_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_wr_i,
  input  logic        start_rd_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        m_aw_valid_o,
  input  logic        m_aw_ready_i,
  output logic [6:0]  m_aw_addr_o,
  output logic        m_w_valid_o,
  input  logic        m_w_ready_i,
  output logic [31:0] m_w_data_o,
  output logic [3:0]  m_w_strb_o,
  input  logic        m_b_valid_i,
  output logic        m_b_ready_o,
  input  logic [1:0]  m_b_resp_i,
  output logic        m_ar_valid_o,
  input  logic        m_ar_ready_i,
  output logic [6:0]  m_ar_addr_o,
  input  logic        m_r_valid_i,
  output logic        m_r_ready_o,
  input  logic [31:0] m_r_data_i,
  input  logic [1:0]  m_r_resp_i
);
  logic        aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q, done_q, err_q;
  logic [6:0]  aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q, rdata_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      rdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (aw_valid_q && m_aw_ready_i) aw_valid_q <= 1'b0;
      if (w_valid_q && m_w_ready_i) w_valid_q <= 1'b0;
      if (b_ready_q && m_b_valid_i) begin
        b_ready_q <= 1'b0;
        done_q    <= 1'b1;
        err_q     <= |m_b_resp_i;
      end
      if (ar_valid_q && m_ar_ready_i) begin
        ar_valid_q <= 1'b0;
        r_ready_q  <= 1'b1;
      end
      if (r_ready_q && m_r_valid_i) begin
        r_ready_q <= 1'b0;
        done_q    <= 1'b1;
        err_q     <= |m_r_resp_i;
        rdata_q   <= m_r_data_i;
      end
      if (start_wr_i) begin
        aw_valid_q <= 1'b1;
        w_valid_q  <= 1'b1;
        b_ready_q  <= 1'b1;
        aw_addr_q  <= addr_i;
        w_data_q   <= data_i;
      end
      if (start_rd_i) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= addr_i;
      end
    end
  end
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign m_aw_valid_o = aw_valid_q;
  assign m_aw_addr_o  = aw_addr_q;
  assign m_w_valid_o  = w_valid_q;
  assign m_w_data_o   = w_data_q;
  assign m_w_strb_o   = 4'hF;
  assign m_b_ready_o  = b_ready_q;
  assign m_ar_valid_o = ar_valid_q;
  assign m_ar_addr_o  = ar_addr_q;
  assign m_r_ready_o  = r_ready_q;
endmodule

// File: rtl/spi_lite_sequencer.sv
// spi_lite_sequencer: command-driven AXI-lite master for the quad-SPI controller IP
module spi_lite_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [31:0] SPICR_INIT = 32'h0000_0086,
  parameter int          POLL_LIMIT = 1024,
  parameter int          POLL_W     = 11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [7:0]  cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_err_o,
  output logic        init_done_o,
  output logic        m_aw_valid_o,
  input  logic        m_aw_ready_i,
  output logic [6:0]  m_aw_addr_o,
  output logic        m_w_valid_o,
  input  logic        m_w_ready_i,
  output logic [31:0] m_w_data_o,
  output logic [3:0]  m_w_strb_o,
  input  logic        m_b_valid_i,
  output logic        m_b_ready_o,
  input  logic [1:0]  m_b_resp_i,
  output logic        m_ar_valid_o,
  input  logic        m_ar_ready_i,
  output logic [6:0]  m_ar_addr_o,
  input  logic        m_r_valid_i,
  output logic        m_r_ready_o,
  input  logic [31:0] m_r_data_i,
  input  logic [1:0]  m_r_resp_i
);
  state_e              state_q;
  logic                issued_q, err_q, cmd_ready_q, rsp_valid_q, rsp_err_q, init_done_q;
  logic [7:0]          tx_q, rsp_data_q;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                is_wr, is_rd, start_wr, start_rd, eng_done, eng_err;
  logic [6:0]          acc_addr;
  logic [31:0]         acc_data, eng_rdata;
  logic                unused_rdata;
  always_comb begin
    is_wr      = state_q inside {S_INIT_SRR, S_INIT_CR, S_INIT_SS, S_CS_ASSERT, S_CS_DEASSERT, S_WR_DTR};
    is_rd      = state_q inside {S_POLL, S_RD_DRR};
    start_wr   = is_wr && !issued_q;
    start_rd   = is_rd && !issued_q;
    acc_addr   = state_q == S_INIT_SRR ? ADDR_SRR :
                 state_q == S_INIT_CR  ? ADDR_SPICR :
                 state_q == S_WR_DTR   ? ADDR_DTR :
                 state_q == S_POLL     ? ADDR_SPISR :
                 state_q == S_RD_DRR   ? ADDR_DRR : ADDR_SSR;
    acc_data   = state_q == S_INIT_SRR  ? SRR_KEY :
                 state_q == S_INIT_CR   ? SPICR_INIT :
                 state_q == S_CS_ASSERT ? SSR_SEL :
                 state_q == S_WR_DTR    ? {24'h0, tx_q} : SSR_DESEL;
    poll_cnt_d = poll_cnt_q + 1'b1;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_INIT_SRR;
      issued_q    <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
      tx_q        <= '0;
      poll_cnt_q  <= '0;
    end else begin
      if (start_wr || start_rd) issued_q <= 1'b1;
      if (eng_done) begin
        issued_q <= 1'b0;
        err_q    <= err_q | eng_err;
      end
      case (state_q)
        S_INIT_SRR: if (eng_done) state_q <= S_INIT_CR;
        S_INIT_CR:  if (eng_done) state_q <= S_INIT_SS;
        S_INIT_SS: if (eng_done) begin
          state_q     <= S_IDLE;
          init_done_q <= 1'b1;
          cmd_ready_q <= 1'b1;
        end
        S_IDLE: if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_q <= 1'b0;
          tx_q        <= cmd_data_i;
          poll_cnt_q  <= '0;
          err_q       <= 1'b0;
          rsp_data_q  <= '0;
          case (op_e'(cmd_op_i))
            OP_XFER:        state_q <= S_WR_DTR;
            OP_CS_ASSERT:   state_q <= S_CS_ASSERT;
            OP_CS_DEASSERT: state_q <= S_CS_DEASSERT;
            default: begin
              state_q <= S_RESP;
              err_q   <= 1'b1;
            end
          endcase
        end
        S_CS_ASSERT, S_CS_DEASSERT: if (eng_done) state_q <= S_RESP;
        S_WR_DTR: if (eng_done) state_q <= S_POLL;
        S_POLL: if (eng_done) begin
          poll_cnt_q <= poll_cnt_d;
          if (!eng_rdata[0]) state_q <= S_RD_DRR;
          else if (poll_cnt_d == POLL_W'(POLL_LIMIT)) begin
            state_q <= S_RESP;
            err_q   <= 1'b1;
          end
        end
        S_RD_DRR: if (eng_done) begin
          rsp_data_q <= eng_rdata[7:0];
          state_q    <= S_RESP;
        end
        S_RESP: if (!rsp_valid_q) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
        end else if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_INIT_SRR;
      endcase
    end
  end
  axi_lite_master_port u_port (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_wr_i   (start_wr),
    .start_rd_i   (start_rd),
    .addr_i       (acc_addr),
    .data_i       (acc_data),
    .done_o       (eng_done),
    .rdata_o      (eng_rdata),
    .err_o        (eng_err),
    .m_aw_valid_o (m_aw_valid_o),
    .m_aw_ready_i (m_aw_ready_i),
    .m_aw_addr_o  (m_aw_addr_o),
    .m_w_valid_o  (m_w_valid_o),
    .m_w_ready_i  (m_w_ready_i),
    .m_w_data_o   (m_w_data_o),
    .m_w_strb_o   (m_w_strb_o),
    .m_b_valid_i  (m_b_valid_i),
    .m_b_ready_o  (m_b_ready_o),
    .m_b_resp_i   (m_b_resp_i),
    .m_ar_valid_o (m_ar_valid_o),
    .m_ar_ready_i (m_ar_ready_i),
    .m_ar_addr_o  (m_ar_addr_o),
    .m_r_valid_i  (m_r_valid_i),
    .m_r_ready_o  (m_r_ready_o),
    .m_r_data_i   (m_r_data_i),
    .m_r_resp_i   (m_r_resp_i)
  );
  assign unused_rdata = ^eng_rdata[31:8];
  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign init_done_o  = init_done_q;
endmodule

// File: doc/spi_lite_sequencer.md
Name: spi_lite_sequencer

Overview:
- Command-driven master that runs the AXI-lite register port of the quad-SPI controller IP, so SD-card software or a boot engine can issue byte-level SPI operations without touching IP registers directly.
- After reset it initialises the IP: soft reset, then control register, then slave-select register.
- It then serves one command at a time: chip-select assert/deassert, or a full-duplex byte transfer. A byte transfer writes DTR, polls SR until RX is non-empty, then reads DRR.
- Sits between a requester and the 7-bit-address, 32-bit AXI-lite slave side of the SPI IP.

Parameters:
- SPICR_INIT, 32'h0000_0086, control-register value written at init (SPE, master, manual slave select).
- POLL_LIMIT, 1024, maximum SR reads per transfer before an error response.
- POLL_W, 11, width of the poll counter; must satisfy 2^POLL_W > POLL_LIMIT.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also 1
- cmd_op  in  2  0=XFER byte, 1=CS_ASSERT, 2=CS_DEASSERT, 3=reserved
- cmd_data  in  8  TX byte for XFER
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester takes the response
- rsp_data  out  8  RX byte (0 for non-XFER commands)
- rsp_err  out  1  poll timeout, non-OKAY bresp/rresp, or reserved op
- init_done  out  1  high once initialisation is complete
- m_aw_valid, m_aw_ready, m_aw_addr[6:0]  AXI-lite write address (master side)
- m_w_valid, m_w_ready, m_w_data[31:0], m_w_strb[3:0]  write data
- m_b_valid, m_b_ready, m_b_resp[1:0]  write response
- m_ar_valid, m_ar_ready, m_ar_addr[6:0]  read address
- m_r_valid, m_r_ready, m_r_data[31:0], m_r_resp[1:0]  read data

Behaviour:
- Register map constants: SRR=7'h40, SPICR=7'h60, SPISR=7'h64, DTR=7'h68, DRR=7'h6C, SSR=7'h70. SR bit0 = RX_EMPTY.
- Reset values: all valids 0, cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, init_done 0, addresses 0, w_data 0, w_strb 4'hF, b_ready 0, r_ready 0. On reset the FSM returns to INIT_SRR.
- Reset asserted mid-transaction abandons any outstanding AXI handshake; the slave is reset on the same domain.
- Write sub-sequence:
  - aw_valid and w_valid rise in the same cycle.
  - Each valid drops independently on its own handshake.
  - b_ready is held high until the b handshake.
  - Address and data stay stable while the corresponding valid is high.
- Read sub-sequence: ar_valid held until handshake; then r_ready is held high until the r handshake; m_r_data is captured on that handshake.
- Minimum latency per register access is 2 cycles (address/data, then response). No overlapping transactions.
- FSM states:
  - INIT_SRR: write 32'h0000_000A to SRR.
  - INIT_CR: write SPICR_INIT to SPICR.
  - INIT_SS: write 32'hFFFF_FFFF to SSR (all deselected), then set init_done and go to IDLE.
  - IDLE: cmd_ready=1 only when init_done=1 and rsp_valid=0. On accept, dispatch on cmd_op.
  - CS_ASSERT: write 32'hFFFF_FFFE to SSR, then go to RESP.
  - CS_DEASSERT: write 32'hFFFF_FFFF to SSR, then go to RESP.
  - WR_DTR: write {24'h0, cmd_data} to DTR, then go to POLL.
  - POLL: read SPISR; increment the poll counter. If bit0=0 go to RD_DRR. Else if count==POLL_LIMIT go to RESP with err=1. Else repeat POLL.
  - RD_DRR: read DRR; rsp_data=r_data[7:0]; go to RESP.
  - RESP: rsp_valid=1 held until rsp_ready, then go to IDLE. cmd_ready stays 0 while rsp_valid=1.
- Reserved op: no AXI traffic; go straight to RESP with rsp_err=1, rsp_data=0.
- Any non-zero bresp/rresp sets a sticky error for the current command.
  - Error during init: still complete the init sequence and set init_done; rsp_err is not used.
  - Error during a command: the sequence continues, and the response is reported with rsp_err=1.
- The poll counter clears on every command accept.
- cmd_data is latched on accept; later changes on the input are ignored.
- A response is emitted exactly once per accepted command.

Decomposition:
- Package spi_seq_pkg:
  - register-address localparams (SRR, SPICR, SPISR, DTR, DRR, SSR);
  - op encoding;
  - FSM state enum;
  - SRR reset key 32'hA;
  - SSR values for deselect and select.
- Sub-module axi_lite_master_port: single-outstanding AXI-lite write/read engine.
  - Inputs: start_wr/start_rd, addr, data.
  - Outputs: done, rdata, err.
  - The top FSM drives only this engine.

Test Plan:
1. Reset release with a slave model of ready=1 and resp=OKAY -> exactly three writes in order: (40,0000000A), (60,00000086), (70,FFFFFFFF); init_done=1 afterwards; cmd_ready=0 before that point.
2. CS_ASSERT, then XFER 8'hFF with the slave returning SR=1 twice then SR=0 and DRR=32'h0000_0001 -> SSR=FFFFFFFE, DTR=000000FF, three SR reads, rsp_data=8'h01, rsp_err=0.
3. XFER with SR permanently 1 and POLL_LIMIT=4 -> exactly 4 SR reads, no DRR read, rsp_err=1; the next command is accepted normally.
4. Slave aw_ready delayed 3 cycles while w_ready is immediate -> w_valid drops after 1 cycle, aw_valid holds 4 cycles, m_aw_addr is stable throughout, one b handshake.
5. rsp_ready held low for 5 cycles with cmd_valid=1 -> rsp_valid and rsp_data stable for those cycles, cmd_ready=0, no AXI activity.
6. Reset asserted during POLL; then a reserved op (3) -> the FSM restarts at INIT_SRR with the full init sequence; the reserved op gives rsp_err=1 and no AXI traffic.
